spi_cmd_arbiter: RTL and testbench

Round-robin arbiter that shares the single `spi_master` command/response interface among `NUM_REQ` requesters in the SPI clock domain. It sits between the AXI4-to-SPI bridge (requester 0) plus other SPI-domain clients (config/boot engines) and `spi_master`. It grants one requester at a time and forwards that requester's command. It holds the grant until the SPI transaction completes, then routes the response back.

---
 rtl/spi_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one spi_master command/response port among NUM_REQ clients.
// Optional WAIT-state watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_cmd_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wr_data,
  input  logic [NUM_REQ*4-1:0]            req_wr_strb,
  input  logic [NUM_REQ-1:0]              req_wr_valid,
  input  logic [NUM_REQ-1:0]              req_rd_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              req_done,
  output logic [DATA_WIDTH-1:0]           req_rd_data,
  output logic [1:0]                      req_resp,
  output logic [ADDR_WIDTH-1:0]           cmd_addr,
  output logic [DATA_WIDTH-1:0]           cmd_wr_data,
  output logic [3:0]                      cmd_wr_strb,
  output logic                            cmd_wr_valid,
  output logic                            cmd_rd_valid,
  input  logic                            cmd_ready,
  input  logic [DATA_WIDTH-1:0]           resp_rd_data,
  input  logic [1:0]                      resp_status,
  input  logic                            resp_rd_done,
  input  logic                            resp_wr_done
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("spi_cmd_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     owner;
  logic              op_wr;
  logic [GW-1:0]     gnt_idx;
  logic              gnt_found;
  logic [NUM_REQ-1:0] pending;
  logic              done_any;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     tmo_cnt;
`endif

  assign pending  = req_wr_valid | req_rd_valid;
  assign done_any = resp_wr_done | resp_rd_done;

  // Search starts one past the previous winner so every client gets a turn.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_grant) + k) % NUM_REQ;
      cand = GW'(idx);
      if (!gnt_found && pending[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Gated by rst so the handshake reads as idle while reset is held.
  assign req_ready = (state == ST_IDLE && gnt_found && !rst)
                     ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_grant   <= GW'(NUM_REQ - 1);
      owner        <= '0;
      op_wr        <= 1'b0;
      cmd_addr     <= '0;
      cmd_wr_data  <= '0;
      cmd_wr_strb  <= '0;
      cmd_wr_valid <= 1'b0;
      cmd_rd_valid <= 1'b0;
      req_done     <= '0;
      req_rd_data  <= '0;
      req_resp     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      req_done <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_found) begin
            cmd_addr     <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            cmd_wr_data  <= req_wr_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            cmd_wr_strb  <= req_wr_strb[int'(gnt_idx)*4 +: 4];
            // A write wins when both valids are up; the read stays pending.
            op_wr        <= req_wr_valid[gnt_idx];
            cmd_wr_valid <= req_wr_valid[gnt_idx];
            cmd_rd_valid <= !req_wr_valid[gnt_idx];
            owner        <= gnt_idx;
            last_grant   <= gnt_idx;
            state        <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_wr_valid <= 1'b0;
            cmd_rd_valid <= 1'b0;
            state        <= ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end
        end

        ST_WAIT: begin
          if (done_any) begin
            req_rd_data <= op_wr ? '0 : resp_rd_data;
            req_resp    <= resp_status;
            req_done    <= NUM_REQ'(1) << owner;
            state       <= ST_IDLE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            req_rd_data <= '0;
            req_resp    <= 2'b10;
            req_done    <= NUM_REQ'(1) << owner;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`else
          else begin
            state <= ST_WAIT;
          end
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed self-checking bench for spi_cmd_arbiter (3 requesters, 32-bit fields).
// Timeout scenario runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_cmd_arbiter;

  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*32-1:0] req_addr;
  logic [NR*32-1:0] req_wr_data;
  logic [NR*4-1:0]  req_wr_strb;
  logic [NR-1:0]    req_wr_valid;
  logic [NR-1:0]    req_rd_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_done;
  logic [31:0]      req_rd_data;
  logic [1:0]       req_resp;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_wr_data;
  logic [3:0]       cmd_wr_strb;
  logic             cmd_wr_valid;
  logic             cmd_rd_valid;
  logic             cmd_ready;
  logic [31:0]      resp_rd_data;
  logic [1:0]       resp_status;
  logic             resp_rd_done;
  logic             resp_wr_done;

  int n_checks = 0;
  int n_fail   = 0;

  spi_cmd_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_wr_strb(req_wr_strb),
    .req_wr_valid(req_wr_valid), .req_rd_valid(req_rd_valid),
    .req_ready(req_ready), .req_done(req_done),
    .req_rd_data(req_rd_data), .req_resp(req_resp),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data), .cmd_wr_strb(cmd_wr_strb),
    .cmd_wr_valid(cmd_wr_valid), .cmd_rd_valid(cmd_rd_valid), .cmd_ready(cmd_ready),
    .resp_rd_data(resp_rd_data), .resp_status(resp_status),
    .resp_rd_done(resp_rd_done), .resp_wr_done(resp_wr_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    req_addr[i*32 +: 32]    = addr;
    req_wr_data[i*32 +: 32] = data;
    req_wr_strb[i*4 +: 4]   = strb;
    req_wr_valid[i]         = wr;
    req_rd_valid[i]         = rd;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_wr_valid = '0;
    req_rd_valid = '0;
    resp_rd_done = 1'b0;
    resp_wr_done = 1'b0;
    cmd_ready    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction for requester g with cmd_ready high throughout.
  task automatic serve(input int g, input logic wr, input logic drop, input logic both,
                       input logic [31:0] rdata, input logic [1:0] st, input logic [31:0] exp_addr);
    #1;
    check("grant", req_ready, 64'(1) << g);
    tick();
    if (drop) begin
      if (wr) req_wr_valid[g] = 1'b0;
      else    req_rd_valid[g] = 1'b0;
    end
    check("issue_ready_low", req_ready, 0);
    check("issue_wr_valid", cmd_wr_valid, wr);
    check("issue_rd_valid", cmd_rd_valid, !wr);
    check("issue_addr", cmd_addr, exp_addr);
    tick();
    check("wait_valid_clr", {cmd_wr_valid, cmd_rd_valid}, 0);
    resp_rd_data = rdata;
    resp_status  = st;
    resp_rd_done = !wr || both;
    resp_wr_done = wr || both;
    tick();
    resp_rd_done = 1'b0;
    resp_wr_done = 1'b0;
    check("done_owner", req_done, 64'(1) << g);
    check("done_rdata", req_rd_data, wr ? 32'h0 : rdata);
    check("done_resp", req_resp, st);
  endtask

  initial begin
    req_addr     = '0;
    req_wr_data  = '0;
    req_wr_strb  = '0;
    req_wr_valid = '0;
    req_rd_valid = '0;
    resp_rd_data = '0;
    resp_status  = '0;
    resp_rd_done = 1'b0;
    resp_wr_done = 1'b0;
    cmd_ready    = 1'b1;
    rst          = 1'b1;

    // Reset values, with a request already pending to prove req_ready is gated.
    repeat (2) @(posedge clk);
    set_req(2, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_done", req_done, 0);
    check("rst_valids", {cmd_wr_valid, cmd_rd_valid}, 0);
    check("rst_cmd_fields", {cmd_addr, cmd_wr_strb}, 0);
    check("rst_cmd_data", cmd_wr_data, 0);
    check("rst_rdata", req_rd_data, 0);
    check("rst_resp", req_resp, 0);
    do_reset();

    // Single write, done returned five cycles after entering WAIT.
    set_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    #1;
    check("w_grant", req_ready, 3'b001);
    tick();
    req_wr_valid[0] = 1'b0;
    check("w_ready_pulse", req_ready, 0);
    check("w_cmd_wr_valid", cmd_wr_valid, 1);
    check("w_cmd_rd_valid", cmd_rd_valid, 0);
    check("w_cmd_addr", cmd_addr, 32'h10);
    check("w_cmd_data", cmd_wr_data, 32'hDEADBEEF);
    check("w_cmd_strb", cmd_wr_strb, 4'hF);
    tick();
    check("w_valid_1cyc", cmd_wr_valid, 0);
    repeat (4) begin
      check("w_no_early_done", req_done, 0);
      tick();
    end
    resp_wr_done = 1'b1;
    resp_status  = 2'b00;
    resp_rd_data = 32'h55;
    tick();
    resp_wr_done = 1'b0;
    check("w_done", req_done, 3'b001);
    check("w_resp", req_resp, 0);
    check("w_rdata_zero", req_rd_data, 0);
    tick();
    check("w_done_1cyc", req_done, 0);

    // Stray completion while idle.
    resp_rd_done = 1'b1;
    resp_rd_data = 32'h77;
    tick();
    resp_rd_done = 1'b0;
    check("stray_idle_done", req_done, 0);
    check("stray_idle_rdata", req_rd_data, 0);

    // Three-way contention out of reset: grants 0,1,2,0.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b1, 32'h100 + i, 32'h0, 4'h0);
    for (int j = 0; j < 4; j++) serve(j % NR, 1'b0, 1'b0, 1'b0, 32'hA0 + j, 2'b00, 32'h100 + (j % NR));
    req_rd_valid = '0;

    // Read data routing to requester 2.
    tick();
    set_req(2, 1'b0, 1'b1, 32'h200, 32'h0, 4'h0);
    serve(2, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 2'b00, 32'h200);

    // Requester 1 raises both valids; cmd_ready stalls ISSUE for 10 cycles.
    tick();
    cmd_ready = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'h44, 32'h12345678, 4'h3);
    #1;
    check("both_grant", req_ready, 3'b010);
    tick();
    req_wr_valid[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("stall_wr_valid", cmd_wr_valid, 1);
      check("stall_rd_valid", cmd_rd_valid, 0);
      check("stall_fields", {cmd_addr, cmd_wr_strb}, {32'h44, 4'h3});
      check("stall_data", cmd_wr_data, 32'h12345678);
      check("stall_no_grant", req_ready, 0);
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    check("stall_released", cmd_wr_valid, 0);
    resp_wr_done = 1'b1;
    resp_status  = 2'b01;
    resp_rd_data = 32'hFFFF;
    tick();
    resp_wr_done = 1'b0;
    check("both_wr_done", req_done, 3'b010);
    check("both_wr_resp", req_resp, 2'b01);
    check("both_wr_rdata", req_rd_data, 0);
    // Pending read follows; both done strobes at once count as one read completion.
    serve(1, 1'b0, 1'b1, 1'b1, 32'h0BADCAFE, 2'b00, 32'h44);
    tick();
    check("after_dual_done", req_done, 0);

`ifdef SPI_ARB_TIMEOUT_EN
    set_req(0, 1'b1, 1'b0, 32'h80, 32'h1, 4'hF);
    #1;
    tick();
    req_wr_valid[0] = 1'b0;
    tick();
    repeat (15) begin
      tick();
      check("tmo_not_yet", req_done, 0);
    end
    tick();
    check("tmo_done", req_done, 3'b001);
    check("tmo_resp", req_resp, 2'b10);
    check("tmo_rdata", req_rd_data, 0);
    tick();
    resp_rd_done = 1'b1;
    resp_rd_data = 32'h1234;
    tick();
    resp_rd_done = 1'b0;
    check("tmo_late_done", req_done, 0);
    check("tmo_late_rdata", req_rd_data, 0);
`endif

    // Reset asserted mid-cycle while in WAIT; last_grant is 0 beforehand.
    set_req(0, 1'b1, 1'b0, 32'h90, 32'h2, 4'hF);
    #1;
    tick();
    req_wr_valid[0] = 1'b0;
    tick();
    set_req(2, 1'b0, 1'b1, 32'h302, 32'h0, 4'h0);
    #3;
    rst = 1'b1;
    #1;
    check("rstw_ready", req_ready, 0);
    check("rstw_done", req_done, 0);
    check("rstw_valids", {cmd_wr_valid, cmd_rd_valid}, 0);
    check("rstw_addr", cmd_addr, 0);
    check("rstw_resp", {req_resp, req_rd_data}, 0);
    set_req(0, 1'b0, 1'b1, 32'h300, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    serve(0, 1'b0, 1'b1, 1'b0, 32'h11, 2'b00, 32'h300);
    serve(2, 1'b0, 1'b1, 1'b0, 32'h22, 2'b00, 32'h302);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
